// File: rtl/gray_2_bin.sv
// ---------------------------------------------------------------------------
// gray_2_bin
//
// Purpose:
//   Gray-code to binary converter for values arriving from a synchroniser,
//   such as async FIFO read/write pointers that have crossed a clock domain.
//   It gives two views of the same conversion:
//     - bin_o: a zero-latency combinational result;
//     - bin_q_o / valid_q_o: a registered copy for logic in the clk_i domain.
//
// Optional build feature (macro GRAY_2_BIN_STEP_CHECK_EN):
//   When the macro is defined, the block remembers the last accepted code.
//   It raises step_err_o for one cycle whenever two consecutive accepted codes
//   differ in more than one bit. A legal Gray stream never does that.
//   When the macro is undefined, step_err_o is tied to 0 and the step-check
//   registers do not exist.
//
// Handshake:
//   valid_i qualifies gray_i for one rising edge of clk_i. There is no
//   backpressure, so every cycle with valid_i=1 is accepted.
//   valid_q_o is high for exactly the one cycle after an accepted gray_i, and
//   bin_q_o carries that sample's result. With no new sample, bin_q_o holds.
//
// Ports:
//   clk_i       in   1      clock, rising edge
//   arst_i      in   1      asynchronous reset, active high
//   gray_i      in   WIDTH  Gray-coded input value
//   valid_i     in   1      qualifies gray_i for the registered path/checker
//   bin_o       out  WIDTH  combinational binary equivalent of gray_i
//   bin_q_o     out  WIDTH  registered binary result of last accepted gray_i
//   valid_q_o   out  1      one-cycle strobe after each accepted gray_i
//   step_err_o  out  1      registered Gray step-violation pulse
//
// Parameters:
//   WIDTH  bit width of the code (>= 1; odd and even widths both work)
// ---------------------------------------------------------------------------
module gray_2_bin #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [WIDTH-1:0] gray_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] bin_q_o,
    output logic             valid_q_o,
    output logic             step_err_o
);

    // -----------------------------------------------------------------------
    // Combinational conversion
    // -----------------------------------------------------------------------
    // bin[i] is the XOR of gray[WIDTH-1:i]. Shifting right by i puts exactly
    // those bits at the bottom, with zeros above, so a reduction XOR of the
    // shifted word gives bin[i]. Every bit has its own reduction over gray_i,
    // so this does not form a ripple chain through bin itself.
    // An X/Z on gray bit j reaches only the reductions for bits i <= j. That
    // matches the intended X propagation, with no masking.
    logic [WIDTH-1:0] w_bin;

    always_comb begin
        w_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_bin[i] = ^(gray_i >> i);
        end
    end

    assign bin_o = w_bin;

    // -----------------------------------------------------------------------
    // Registered, valid-qualified copy
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] r_bin_q;
    logic             r_valid_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_bin_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= valid_i;
            if (valid_i) begin
                r_bin_q <= w_bin;
            end
        end
    end

    assign bin_q_o   = r_bin_q;
    assign valid_q_o = r_valid_q;

`ifdef GRAY_2_BIN_STEP_CHECK_EN
    // -----------------------------------------------------------------------
    // Gray step checker
    // -----------------------------------------------------------------------
    // r_have_prev stays clear until the first sample is accepted after
    // reset. That sample has no predecessor, so it can never flag.
    logic [WIDTH-1:0] r_prev_gray;
    logic             r_have_prev;
    logic             r_step_err;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_diff_lsb_cleared;
    logic             w_multi_bit;

    // Two or more differing bits is the same as the XOR still being nonzero
    // after its lowest set bit is cleared. This avoids a full popcount.
    assign w_diff             = gray_i ^ r_prev_gray;
    assign w_diff_lsb_cleared = w_diff & (w_diff - {{(WIDTH-1){1'b0}}, 1'b1});
    assign w_multi_bit        = |w_diff_lsb_cleared;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_prev_gray <= '0;
            r_have_prev <= 1'b0;
            r_step_err  <= 1'b0;
        end else begin
            // Default: a pulse lasts one cycle and idle cycles never flag.
            r_step_err <= 1'b0;
            if (valid_i) begin
                r_step_err  <= r_have_prev & w_multi_bit;
                r_prev_gray <= gray_i;
                r_have_prev <= 1'b1;
            end
        end
    end

    assign step_err_o = r_step_err;
`else
    assign step_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_2_bin.sv
// ---------------------------------------------------------------------------
// tb_gray_2_bin
//
// Directed testbench for gray_2_bin with WIDTH=8. It checks:
//   - the combinational path with no clock running and reset held;
//   - boundary codes;
//   - random codes against an iterative reference model;
//   - the registered path and asynchronous reset;
//   - the step checker, which must stay silent when the macro is undefined.
// ---------------------------------------------------------------------------
module tb_gray_2_bin;

    localparam int W = 8;

`ifdef GRAY_2_BIN_STEP_CHECK_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic         clk    = 1'b0;
    bit           clk_en = 1'b0;
    logic         arst;
    logic [W-1:0] gray;
    logic         valid;
    logic [W-1:0] bin;
    logic [W-1:0] bin_q;
    logic         valid_q;
    logic         step_err;

    // The clock stays frozen until clk_en is set, so the first checks run
    // with no clock edges at all.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    gray_2_bin #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .arst_i     (arst),
        .gray_i     (gray),
        .valid_i    (valid),
        .bin_o      (bin),
        .bin_q_o    (bin_q),
        .valid_q_o  (valid_q),
        .step_err_o (step_err)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model written as a ripple from the MSB down.
    function automatic logic [W-1:0] ref_conv(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Wait for the next rising edge, then step off it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] g);
        valid = 1'b1;
        gray  = g;
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] r;
        logic [W-1:0] m;

        arst  = 1'b1;
        valid = 1'b0;
        gray  = 8'h00;

        // Combinational path: no clock running, reset held high.
        for (int k = 0; k < 10; k++) begin
            #10;
            check("comb_zero_in_reset", bin, 8'h00);
        end
        check("reset_bin_q",    bin_q,            8'h00);
        check("reset_valid_q",  {7'd0, valid_q},  8'h00);
        check("reset_step_err", {7'd0, step_err}, 8'h00);

        gray = 8'hFF; #10; check("comb_ff", bin, 8'hAA);
        gray = 8'hAA; #10; check("comb_aa", bin, 8'hCC);
        gray = 8'h22; #10; check("comb_22", bin, 8'h3C);
        gray = 8'h80; #10; check("comb_80", bin, 8'hFF);
        gray = 8'h01; #10; check("comb_01", bin, 8'h01);

        // Random codes against the reference model.
        for (int k = 0; k < 1000; k++) begin
            r    = 8'($urandom_range(0, 255));
            gray = r;
            #10;
            check("comb_random", bin, ref_conv(r));
        end

        // A deliberately corrupted LSB must not match the reference model.
        gray = 8'h5A;
        #10;
        m = bin ^ 8'h01;
        n_checks++;
        assert (m !== ref_conv(8'h5A))
        else begin
            n_fail++;
            $error("FAIL flipped_lsb_detect observed=%h expected_differs_from=%h",
                   m, ref_conv(8'h5A));
        end

        // Clocked path.
        gray   = 8'h00;
        clk_en = 1'b1;
        tick();
        tick();
        check("rst_held_valid_q", {7'd0, valid_q}, 8'h00);
        arst = 1'b0;
        tick();
        check("post_rst_valid_q", {7'd0, valid_q}, 8'h00);

        accept(8'h80);
        check("q_80_bin_q",   bin_q,           8'hFF);
        check("q_80_valid_q", {7'd0, valid_q}, 8'h01);
        valid = 1'b0;
        tick();
        check("idle_valid_q", {7'd0, valid_q}, 8'h00);
        check("idle_hold",    bin_q,           8'hFF);

        // Asynchronous reset mid-cycle: it must clear at once, with no edge.
        #2;
        arst = 1'b1;
        #1;
        check("async_rst_bin_q",   bin_q,           8'h00);
        check("async_rst_valid_q", {7'd0, valid_q}, 8'h00);
        tick();
        arst = 1'b0;
        tick();

        // Step-checker sequence. The registered path must match in both builds.
        accept(8'h00);
        check("s00_step",  {7'd0, step_err}, 8'h00);
        check("s00_bin_q", bin_q,            8'h00);
        check("s00_valid", {7'd0, valid_q},  8'h01);

        accept(8'h01);
        check("s01_step",  {7'd0, step_err}, 8'h00);
        check("s01_bin_q", bin_q,            8'h01);

        accept(8'h07);
        check("s07_step",  {7'd0, step_err}, {7'd0, STEP_EN});
        check("s07_bin_q", bin_q,            8'h05);

        accept(8'h07);
        check("s07_repeat_step", {7'd0, step_err}, 8'h00);
        check("s07_repeat_bin",  bin_q,            8'h05);

        valid = 1'b0;
        tick();
        check("idle_step",  {7'd0, step_err}, 8'h00);
        check("idle_valid", {7'd0, valid_q},  8'h00);

        // 07 -> 80 differs in four bits, so it flags when the checker is built.
        accept(8'h80);
        check("s80_step",  {7'd0, step_err}, {7'd0, STEP_EN});
        check("s80_bin_q", bin_q,            8'hFF);

        // Wrap from the max code back to 0 is a single-bit step.
        accept(8'h00);
        check("wrap_step",  {7'd0, step_err}, 8'h00);
        check("wrap_bin_q", bin_q,            8'h00);

        // After reset the first sample has no predecessor. 00 -> FF would
        // flag if the history had survived the reset.
        valid = 1'b0;
        #2;
        arst = 1'b1;
        #1;
        check("rst2_step", {7'd0, step_err}, 8'h00);
        tick();
        arst = 1'b0;
        tick();
        accept(8'hFF);
        check("first_after_rst_step", {7'd0, step_err}, 8'h00);
        check("first_after_rst_bin",  bin_q,            8'hAA);

        // Back-to-back samples: one result per cycle.
        accept(8'hFE);
        check("b2b_fe_bin",  bin_q,            8'hAB);
        check("b2b_fe_step", {7'd0, step_err}, 8'h00);
        accept(8'hFC);
        check("b2b_fc_bin",   bin_q,           8'hA8);
        check("b2b_fc_valid", {7'd0, valid_q}, 8'h01);
        valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    // Safety net: never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gray_2_bin.md
Name: gray_2_bin

Overview:
- Parameterised Gray-code to binary converter, used on synchroniser outputs such as async FIFO read/write pointers crossing clock domains.
- Provides two outputs:
  - a zero-latency combinational result, `bin_o`;
  - a registered, valid-qualified copy for consumers in the `clk_i` domain.
- Optionally flags a Gray-code step violation (two consecutive accepted codes differing in more than one bit).

Parameters:
- WIDTH, 8, bit width of the Gray input and the binary outputs. Legal values: WIDTH >= 1. Odd and even widths are both supported.

Ports:
- clk_i  input  1  clock; all registered logic updates on the rising edge.
- arst_i  input  1  asynchronous reset, active high.
- gray_i  input  WIDTH  Gray-coded input value.
- valid_i  input  1  qualifies gray_i for the registered path and the step checker.
- bin_o  output  WIDTH  combinational binary equivalent of gray_i.
- bin_q_o  output  WIDTH  registered binary result of the last accepted gray_i.
- valid_q_o  output  1  high for one cycle after each accepted gray_i.
- step_err_o  output  1  registered Gray step-violation flag. Tied to 0 when the feature is compiled out.

Behaviour:
- Conversion function:
  - bin[WIDTH-1] = gray[WIDTH-1]
  - for i = WIDTH-2 down to 0: bin[i] = bin[i+1] XOR gray[i]
  - Equivalently, bin[i] is the XOR of gray[WIDTH-1:i].
- bin_o (combinational path):
  - Purely combinational from gray_i.
  - No dependence on clk_i, arst_i or valid_i.
  - Correct even with no clock running and reset asserted.
  - Settles within the same delta/timestep as a gray_i change.
  - X/Z on any gray_i bit may propagate to bin_o bits at or below that position. No masking.
- Registered path:
  - On a rising clk_i with valid_i=1: bin_q_o <= conv(gray_i) and valid_q_o <= 1. Latency is 1 cycle.
  - On a rising clk_i with valid_i=0: valid_q_o <= 0 and bin_q_o holds its previous value.
  - Back-to-back valid_i is fully supported: one result per cycle, no backpressure.
- Reset:
  - While arst_i=1: bin_q_o=0, valid_q_o=0, step_err_o=0, and all internal state is cleared.
  - Reset takes effect immediately and asynchronously. Deassertion is sampled at clk_i.
  - Reset asserted mid-stream discards any in-flight result. The first valid_i after reset is treated as having no predecessor.
- Boundary values (WIDTH=8):
  - gray 0x00 gives bin 0x00.
  - gray 0xFF gives bin 0xAA.
  - gray 0x80 gives bin 0xFF.
- WIDTH=1: bin equals gray.

Optional Feature:
- Macro: GRAY_2_BIN_STEP_CHECK_EN.
- When defined:
  - Internal registers prev_gray (WIDTH bits) and have_prev (1 bit) are added; both reset to 0.
  - On each accepted valid_i:
    - If have_prev=1 and popcount(gray_i XOR prev_gray) > 1, then step_err_o <= 1. Otherwise step_err_o <= 0.
    - Then prev_gray <= gray_i and have_prev <= 1.
  - A repeated identical code (distance 0) is legal.
  - Wrap-around (max code back to 0 in reflected Gray) is distance 1 and therefore legal.
  - When valid_i=0, step_err_o <= 0.
  - step_err_o is a single-cycle pulse, aligned with the valid_q_o of the offending sample.
- When not defined: step_err_o is constant 0, and no step-check registers exist.
- bin_o, bin_q_o and valid_q_o behave identically in both builds.

Test Plan:
- gray_i=0x00, no clock, arst_i held high -> bin_o=0x00 after 10 time units. Repeat 10 times.
- gray_i=0xFF -> bin_o=0xAA. Also gray_i=0xAA (checkerboard) -> bin_o=0xCC. Also gray_i=0x22 -> bin_o=0x3C.
- 1000 random gray_i values, each held for 10 time units -> bin_o matches the XOR-prefix reference model every time, with 0 mismatches. The scoreboard must also be shown to flag a deliberately flipped LSB.
- Clocked path: arst_i pulse, then valid_i=1 with gray_i=0x80 for one cycle -> next cycle bin_q_o=0xFF and valid_q_o=1. The following cycle with valid_i=0 -> valid_q_o=0 and bin_q_o holds 0xFF. Asserting arst_i mid-cycle -> bin_q_o=0 and valid_q_o=0 immediately.
- GRAY_2_BIN_STEP_CHECK_EN defined:
  - accept 0x00 then 0x01 -> step_err_o=0;
  - then accept 0x07 -> step_err_o=1 for exactly one cycle;
  - then accept 0x07 again -> step_err_o=0.
  - The first sample after reset never flags.
- GRAY_2_BIN_STEP_CHECK_EN undefined, same stimulus -> step_err_o stays 0, and bin_q_o/valid_q_o are unchanged from the defined build.
